// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared piece codes, board constants and sequencer state encodings
package chess_pkg;

   localparam int NUM_SQUARES = 64;
   localparam int COLOR_BIT   = 3;

   localparam logic WHITE = 1'b0;
   localparam logic BLACK = 1'b1;

   typedef enum logic [2:0] {
      PIECE_EMPTY   = 3'd0,
      PIECE_PAWN    = 3'd1,
      PIECE_KNIGHT  = 3'd2,
      PIECE_BISHOP  = 3'd3,
      PIECE_ROOK    = 3'd4,
      PIECE_QUEEN   = 3'd5,
      PIECE_KING    = 3'd6,
      PIECE_ILLEGAL = 3'd7
   } pieceType_t;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_READ     = 3'd1;
   localparam logic [2:0] S_WAIT     = 3'd2;
   localparam logic [2:0] S_CHECK    = 3'd3;
   localparam logic [2:0] S_ISSUE    = 3'd4;
   localparam logic [2:0] S_GEN_WAIT = 3'd5;
   localparam logic [2:0] S_NEXT     = 3'd6;
   localparam logic [2:0] S_FINISH   = 3'd7;

   // The illegal type code is deliberately treated like an empty square.
   function automatic logic isOwnPiece(input logic [3:0] code, input logic sideToMove);
      pieceType_t pType;
      pType = pieceType_t'(code[2:0]);
      return (pType != PIECE_EMPTY) && (pType != PIECE_ILLEGAL) && (code[COLOR_BIT] == sideToMove);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating counter with clear, increment and sticky overflow
module sat_counter #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             overflow
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (inc) begin
         if (count == WIDTH'(MAX)) begin
            overflow <= 1'b1;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/move_gen_sequencer.sv
// rtl/move_gen_sequencer.sv - scans the board RAM and hands own pieces to the move generator
module move_gen_sequencer
   import chess_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int MAX_MOVES  = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       side,
   output logic       board_rd_en,
   output logic [5:0] board_addr,
   input  logic [3:0] board_rd_data,
   output logic       gen_valid,
   input  logic       gen_ready,
   output logic [5:0] gen_square,
   output logic [3:0] gen_piece,
   input  logic       gen_done,
   input  logic       move_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] move_count,
   output logic       overflow
);

   logic [2:0] state;
   logic [5:0] sq;
   logic       sideReg;
   logic [3:0] pieceReg;
   logic [1:0] waitCnt;
   logic       startAccept;

   assign startAccept = (state == S_IDLE) && start && !abort;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         sq       <= '0;
         sideReg  <= 1'b0;
         pieceReg <= '0;
         waitCnt  <= '0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sideReg <= side;
                  sq      <= '0;
                  state   <= S_READ;
               end
            end
            S_READ: begin
               waitCnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (waitCnt == 2'(RD_LATENCY - 1)) begin
                  state <= S_CHECK;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            S_CHECK: begin
               pieceReg <= board_rd_data;
               state    <= isOwnPiece(board_rd_data, sideReg) ? S_ISSUE : S_NEXT;
            end
            S_ISSUE: begin
               if (gen_ready) begin
                  state <= gen_done ? S_NEXT : S_GEN_WAIT;
               end
            end
            S_GEN_WAIT: begin
               if (gen_done) begin
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (sq == 6'(NUM_SQUARES - 1)) begin
                  state <= S_FINISH;
               end else begin
                  sq    <= sq + 1'b1;
                  state <= S_READ;
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode only registered state so no input reaches an output combinationally.
   assign board_rd_en = (state == S_READ);
   assign board_addr  = sq;
   assign gen_valid   = (state == S_ISSUE);
   assign gen_square  = sq;
   assign gen_piece   = pieceReg;
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_FINISH);

   sat_counter #(
      .WIDTH (8),
      .MAX   (MAX_MOVES)
   ) moveCounter (
      .clk      (clk),
      .reset    (reset),
      .clear    (startAccept),
      .inc      (move_valid && (state != S_IDLE)),
      .count    (move_count),
      .overflow (overflow)
   );

endmodule

// File: doc/move_gen_sequencer.md
Name: move_gen_sequencer

Overview:
- Hardware move-generation scheduler between the top-level control FSM and the per-piece move generator.
- On a start pulse (issued when control enters its send/generate state), it scans all 64 board squares via a read port on the board RAM.
- For every square holding a piece of the side to move, it hands the square to the piece move generator with a valid/ready handshake and waits for that square's completion.
- It counts emitted moves and reports done, so control can release software_stop.

Parameters:
- RD_LATENCY, 1, board RAM read latency in cycles (legal 1..3).
- MAX_MOVES, 255, saturation value of move_count; must fit in 8 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a scan; honoured only in IDLE
- abort  in  1  cancel the scan in progress
- side  in  1  side to move, sampled at start accept (0 white, 1 black)
- board_rd_en  out  1  board RAM read strobe
- board_addr  out  6  square index 0..63 (a1=0, h8=63)
- board_rd_data  in  4  piece code returned RD_LATENCY cycles after board_rd_en
- gen_valid  out  1  square/piece offered to the generator
- gen_ready  in  1  generator accepts the offer
- gen_square  out  6  square being offered
- gen_piece  out  4  piece code being offered
- gen_done  in  1  generator has finished all moves for the accepted square
- move_valid  in  1  generator emitted one move this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  high for exactly one cycle on normal completion
- move_count  out  8  moves counted in the current or last scan
- overflow  out  1  sticky; move_count saturated during the scan

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset mid-scan behaves the same as abort, with counters also cleared.
- Piece code: bit3 is the colour; bits2:0 are the type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 illegal, treated as empty).
- IDLE:
  - start=1 and abort=0 accepted: latch side, clear move_count and overflow, set sq=0, go to READ.
  - start and abort in the same cycle: abort wins; stay in IDLE.
- READ: board_rd_en=1 and board_addr=sq for exactly one cycle, then go to WAIT.
- WAIT: hold for RD_LATENCY cycles with board_rd_en=0, then go to CHECK.
- CHECK: register board_rd_data.
  - Type nonzero and colour==side: go to ISSUE.
  - Otherwise: go to NEXT.
- ISSUE: gen_valid=1, with gen_square and gen_piece held stable until gen_ready.
  - On the handshake, with gen_done=0 that cycle: go to GEN_WAIT.
  - On the handshake, with gen_done=1 that cycle: go to NEXT.
- GEN_WAIT: gen_valid=0; wait for gen_done, then go to NEXT. There is no timeout.
- NEXT:
  - sq==63: go to FINISH.
  - Otherwise: sq+1 and go to READ. sq never wraps.
- FINISH: done=1 for one cycle, then IDLE. move_count and overflow hold until the next accepted start.
- Timing: each skipped square costs exactly 3+RD_LATENCY cycles (READ, WAIT, CHECK, NEXT). An empty board with RD_LATENCY=1 therefore gives busy high for 64*4+1 = 257 cycles, including FINISH.
- move_count: increments on move_valid in any non-IDLE state.
  - At MAX_MOVES it holds and overflow sets.
  - move_valid in IDLE is ignored.
- start while busy: ignored, with no effect on the scan.
- abort in any non-IDLE state: IDLE on the next edge, gen_valid dropped immediately (registered low next cycle), no done pulse, move_count frozen.
- gen_done outside ISSUE/GEN_WAIT: ignored.
- busy = (state != IDLE).
- done, gen_valid and board_rd_en are decoded from the registered state; there are no combinational paths from inputs to outputs.

Decomposition:
- chess_pkg holds the shared constants:
  - piece type codes, COLOR_BIT=3, PIECE_EMPTY
  - WHITE/BLACK
  - NUM_SQUARES=64
  - the sequencer state encodings: IDLE, READ, WAIT, CHECK, ISSUE, GEN_WAIT, NEXT, FINISH, as a 3-bit encoding
- One natural sub-module is sat_counter: an 8-bit saturating counter with clear, increment and sticky overflow. It is reusable for the perft counters.
- The square scan FSM stays inline.

Test Plan:
1. Empty board, RD_LATENCY=1, start at cycle 0 -> no gen_valid; busy high for 257 cycles; done single pulse in the final busy cycle; move_count=0.
2. Initial position, side=0, generator acks ready immediately and emits 2 moves/square then gen_done -> exactly 16 handshakes on squares 0..15 in order; move_count=32; squares 48..63 never offered.
3. Same position with side=1, gen_ready delayed 5 cycles per offer -> gen_square/gen_piece stable while gen_valid is high; offers go to squares 48..63 only.
4. abort raised while in GEN_WAIT on square 4 -> IDLE next cycle; no done pulse; busy low; a new start rescans from square 0 with move_count cleared.
5. Generator emits 300 move_valid pulses -> move_count=255 and overflow=1 through done; next start clears both to 0.
6. start and abort asserted together in IDLE, and start pulsed mid-scan -> first is ignored with busy remaining 0; second leaves scan order and cycle count unchanged.
